// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the main memory port between icache refill and dcache refill/writeback (round-robin via MEM_ARB_ROUND_ROBIN_EN)
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_mem_read,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  output logic                  i_mem_busywait,
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [DATA_WIDTH-1:0] d_mem_writedata,
  output logic                  d_mem_busywait,
  output logic [DATA_WIDTH-1:0] mem_readdata_out,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_busywait
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;
  state_t state_q;
  owner_t owner_q, last_owner_q;
  logic mem_read_q, mem_write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic i_req, d_req, grant_d;
  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign grant_d = d_req & (~i_req | (last_owner_q != OWN_D));
`else
  assign grant_d = d_req | (i_req & (last_owner_q == OWN_NONE));
`endif
  assign i_mem_busywait = i_mem_read & ~(state_q == DONE && owner_q == OWN_I);
  assign d_mem_busywait = d_req & ~(state_q == DONE && owner_q == OWN_D);
  assign mem_read = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_address = addr_q;
  assign mem_writedata = wdata_q;
  assign mem_readdata_out = rdata_q;
  // Grant in IDLE, hold the request through ISSUE/WAIT, hand completion to the owner in DONE
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      last_owner_q <= OWN_I;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_req | d_req) begin
          state_q <= ISSUE;
          owner_q <= grant_d ? OWN_D : OWN_I;
          mem_write_q <= grant_d & d_mem_write;
          mem_read_q <= grant_d ? ~d_mem_write : 1'b1;
          addr_q <= grant_d ? d_mem_address : i_mem_address;
          if (grant_d) wdata_q <= d_mem_writedata;
        end
        ISSUE: if (mem_busywait) state_q <= WAIT;
        WAIT: if (!mem_busywait) begin
          if (mem_read_q) rdata_q <= mem_readdata;
          mem_read_q <= 1'b0;
          mem_write_q <= 1'b0;
          state_q <= DONE;
        end
        DONE: begin
          last_owner_q <= owner_q;
          owner_q <= OWN_NONE;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench with a behavioural main memory
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int BUSY = 5;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  logic i_mem_read = 1'b0, d_mem_read = 1'b0, d_mem_write = 1'b0;
  logic [AW-1:0] i_mem_address = '0, d_mem_address = '0;
  logic [DW-1:0] d_mem_writedata = '0;
  logic i_mem_busywait, d_mem_busywait, mem_read, mem_write;
  logic [DW-1:0] mem_readdata_out, mem_writedata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_readdata = '0;
  logic mem_busywait = 1'b0;
  int tests = 0, fails = 0;
  int i_low, d_low, both_low;
  int order[$];
  logic [DW-1:0] i_seen, d_seen;
  logic [AW-1:0] log_addr[$];
  bit log_wr[$];
  logic [DW-1:0] log_wd[$];
  int cnt = 0;
  bit mdone = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  bit exp_last_d = 1'b0;
  bit first_d;
  localparam logic [DW-1:0] DATA_I = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address), .i_mem_busywait(i_mem_busywait),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
    .d_mem_writedata(d_mem_writedata), .d_mem_busywait(d_mem_busywait),
    .mem_readdata_out(mem_readdata_out), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
    return (a == 28'h0000010) ? DATA_I : {4{4'h0, a}};
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      mem_busywait <= 1'b0;
      cnt <= 0;
      mdone <= 1'b0;
    end else if (mem_busywait) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mem_busywait <= 1'b0;
        mem_readdata <= rd_of(cur_addr);
        mdone <= 1'b1;
      end
    end else if ((mem_read || mem_write) && !mdone) begin
      mem_busywait <= 1'b1;
      cnt <= BUSY;
      cur_addr <= mem_address;
      log_addr.push_back(mem_address);
      log_wr.push_back(mem_write);
      log_wd.push_back(mem_writedata);
    end else if (!(mem_read || mem_write)) begin
      mdone <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic serve(input int max_cycles);
    int n = 0;
    i_low = 0; d_low = 0; both_low = 0;
    order.delete();
    while ((i_mem_read || d_mem_read || d_mem_write) && n < max_cycles) begin
      @(negedge clock);
      n++;
      if (i_mem_read && (d_mem_read || d_mem_write) && !i_mem_busywait && !d_mem_busywait) both_low++;
      if (i_mem_read && !i_mem_busywait) begin
        i_low++;
        i_seen = mem_readdata_out;
        order.push_back(1);
        i_mem_read = 1'b0;
      end
      if ((d_mem_read || d_mem_write) && !d_mem_busywait) begin
        d_low++;
        d_seen = mem_readdata_out;
        order.push_back(2);
        if (d_mem_write) d_mem_write = 1'b0;
        else d_mem_read = 1'b0;
      end
    end
    chk("serve_timeout", {125'b0, i_mem_read, d_mem_read, d_mem_write}, '0);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_wr.delete();
    log_wd.delete();
  endtask

  task automatic run_pair(input string tag);
    clear_log();
    first_d = RR ? !exp_last_d : 1'b1;
    @(negedge clock);
    i_mem_read = 1'b1; i_mem_address = 28'h0000030;
    d_mem_read = 1'b1; d_mem_address = 28'h0000040;
    serve(200);
    chk({tag, "_count"}, log_addr.size(), 2);
    chk({tag, "_first"}, log_addr[0], first_d ? 28'h0000040 : 28'h0000030);
    chk({tag, "_second"}, log_addr[1], first_d ? 28'h0000030 : 28'h0000040);
    chk({tag, "_done_order"}, order[0], first_d ? 2 : 1);
    chk({tag, "_held_off"}, both_low, 0);
    chk({tag, "_i_data"}, i_seen, rd_of(28'h0000030));
    chk({tag, "_d_data"}, d_seen, rd_of(28'h0000040));
    exp_last_d = !first_d;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("idle_rdwr", {126'b0, mem_read, mem_write}, '0);
      chk("idle_bw", {126'b0, i_mem_busywait, d_mem_busywait}, '0);
    end
    chk("rst_addr", mem_address, '0);
    chk("rst_wdata", mem_writedata, '0);
    chk("rst_rdata", mem_readdata_out, '0);

    clear_log();
    i_mem_read = 1'b1; i_mem_address = 28'h0000010;
    #1 chk("i_bw_high", i_mem_busywait, 1);
    serve(200);
    chk("i_count", log_addr.size(), 1);
    chk("i_addr", log_addr[0], 28'h0000010);
    chk("i_is_read", log_wr[0], 0);
    chk("i_low_once", i_low, 1);
    chk("i_data", i_seen, DATA_I);
    exp_last_d = 1'b0;

    clear_log();
    d_mem_write = 1'b1; d_mem_address = 28'h0000020; d_mem_writedata = {32{4'h1}};
    serve(200);
    chk("dw_count", log_addr.size(), 1);
    chk("dw_addr", log_addr[0], 28'h0000020);
    chk("dw_is_write", log_wr[0], 1);
    chk("dw_wdata", log_wd[0], {32{4'h1}});
    chk("dw_low_once", d_low, 1);
    chk("dw_rdata_hold", mem_readdata_out, DATA_I);
    exp_last_d = 1'b1;

    clear_log();
    d_mem_write = 1'b1; d_mem_read = 1'b1; d_mem_address = 28'h0000060; d_mem_writedata = {32{4'h3}};
    serve(300);
    chk("dwr_count", log_addr.size(), 2);
    chk("dwr_write_first", log_wr[0], 1);
    chk("dwr_read_second", log_wr[1], 0);
    chk("dwr_low_twice", d_low, 2);
    chk("dwr_rdata", d_seen, rd_of(28'h0000060));
    exp_last_d = 1'b1;

    run_pair("pair1");
    run_pair("pair2");

    clear_log();
    @(negedge clock);
    d_mem_write = 1'b1; d_mem_address = 28'h0000050; d_mem_writedata = {32{4'h2}};
    for (int k = 0; k < 20 && log_addr.size() == 0; k++) @(negedge clock);
    repeat (2) @(negedge clock);
    chk("rw_in_wait", {126'b0, mem_write, mem_busywait}, 2'b11);
    reset = 1'b1;
    @(negedge clock);
    chk("rw_wr_drop", {126'b0, mem_read, mem_write}, '0);
    chk("rw_addr_rst", mem_address, '0);
    chk("rw_rdata_rst", mem_readdata_out, '0);
    chk("rw_bw", {126'b0, i_mem_busywait, d_mem_busywait}, 2'b01);
    reset = 1'b0;
    serve(200);
    chk("rw_count", log_addr.size(), 2);
    chk("rw_regrant_addr", log_addr[1], 28'h0000050);
    chk("rw_regrant_wr", log_wr[1], 1);
    chk("rw_low_once", d_low, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single main data memory port between the instruction cache refill path and the data cache refill/writeback path.
- Sits between icache/dcache miss handlers and main memory.
- Sequences each block transfer through a fixed issue/wait/complete handshake.
- Returns completion to the owning requester only.

Parameters:
- ADDR_WIDTH, 28, block address width (byte address bits [31:4]).
- DATA_WIDTH, 128, block width in bits (4 words).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- i_mem_read  input  1  icache block-read request; held until i_mem_busywait falls.
- i_mem_address  input  ADDR_WIDTH  icache block address.
- i_mem_busywait  output  1  icache stall.
- d_mem_read  input  1  dcache block-read request.
- d_mem_write  input  1  dcache block-writeback request.
- d_mem_address  input  ADDR_WIDTH  dcache block address.
- d_mem_writedata  input  DATA_WIDTH  dcache writeback block.
- d_mem_busywait  output  1  dcache stall.
- mem_readdata_out  output  DATA_WIDTH  latched read block, shared by both requesters.
- mem_read  output  1  to main memory.
- mem_write  output  1  to main memory.
- mem_address  output  ADDR_WIDTH  to main memory.
- mem_writedata  output  DATA_WIDTH  to main memory.
- mem_readdata  input  DATA_WIDTH  from main memory.
- mem_busywait  input  1  from main memory; high while a transfer is in progress.

Behaviour:
- Clock and reset: one clock. reset is synchronous, active-high.
- Reset values:
  - state=IDLE, owner=NONE, last_owner=I.
  - mem_read, mem_write = 0. mem_address, mem_writedata, mem_readdata_out = 0.
- Requester busywait (combinational):
  - i_mem_busywait = i_mem_read AND NOT(state==DONE AND owner==I).
  - d_mem_busywait = (d_mem_read|d_mem_write) AND NOT(state==DONE AND owner==D).
- States:
  - IDLE:
    - Samples requests. If dcache requests, owner=D. Else if icache requests, owner=I. Else stay.
    - Dcache has fixed priority when both request in the same cycle.
    - Next state ISSUE. Latch address, write data and read/write kind into registers.
  - ISSUE:
    - Drive the registered mem_read or mem_write and mem_address/mem_writedata.
    - Stay until mem_busywait==1, then go to WAIT.
  - WAIT:
    - Keep the memory request asserted.
    - When mem_busywait==0: latch mem_readdata into mem_readdata_out (reads only), deassert mem_read/mem_write on the next edge, go to DONE.
  - DONE:
    - One cycle. Owner's busywait is low, and mem_readdata_out is valid this cycle.
    - Set last_owner=owner, owner=NONE, go to IDLE.
- Latency: minimum 3 cycles of arbiter overhead plus the memory busy period. A request is never granted back-to-back without an IDLE cycle.
- Boundary conditions:
  - If d_mem_read and d_mem_write are both high, write wins and the read is served as a separate later grant.
  - A non-owner request asserted mid-transfer is held off. Its busywait stays high and it is arbitrated in the next IDLE.
  - An owner dropping its request mid-transfer does not abort the transfer. It completes to memory and DONE still occurs.
  - Reset mid-transfer:
    - Next edge returns to IDLE and drops mem_read/mem_write.
    - Requester busywaits follow their request inputs.
    - The interrupted transfer is not retried.
  - mem_readdata_out holds its value after writes and outside DONE.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
  - Defined: on simultaneous requests in IDLE, the grant goes to the requester that is not last_owner. Neither requester waits for more than one foreign transfer.
  - Not defined: fixed dcache priority. last_owner is still tracked but unused.

Test Plan:
- Reset held 2 cycles, then released with no requests:
  - All mem_* outputs are 0 and both busywaits are 0.
  - State remains IDLE for 10 cycles.
- icache read, address 0x0000010, memory busy 5 cycles, data 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D:
  - mem_read=1 with address 0x0000010.
  - i_mem_busywait falls for exactly one cycle, with mem_readdata_out equal to the data.
- dcache write, address 0x0000020, data 0x1111…1111:
  - mem_write=1 and mem_writedata matches.
  - Memory sees exactly one write.
  - d_mem_busywait falls for one cycle.
- Simultaneous i-read 0x30 and d-read 0x40, macro undefined:
  - Memory sees 0x40, then 0x30.
  - The icache busywait stays high throughout the dcache transfer.
- Same stimulus repeated twice, macro defined, last_owner=D after the first pair:
  - The second pair serves 0x30 first.
- Reset asserted during WAIT of a dcache write:
  - mem_write=0 on the next edge and state returns to IDLE.
  - d_mem_busywait remains high while d_mem_write is held.
  - A new grant occurs after reset deasserts.
